ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Multi-master AHB arbiter; shares one AHB slave path (memory slaves, decoder) among NUM_MASTERS.
//  Round-robin grant with burst-aware handover: no re-arbitration inside a fixed-length burst.
//  Drives HGRANT to masters, HMASTER to the address/data muxes, HMASTLOCK to slaves.
// PARAMETERS
//  NUM_MASTERS    4  number of requesting masters (2..8)
//  DEFAULT_MASTER 0  master parked on bus when no requests
//  MW             2  width of HMASTER, = clog2(NUM_MASTERS)
// PORTS
//  HCLK       in   1            AHB clock
//  HRESETn    in   1            async active-low reset
//  HBUSREQ    in   NUM_MASTERS  per-master bus request
//  HLOCK      in   NUM_MASTERS  per-master locked-transfer request
//  HTRANS     in   2            muxed HTRANS of current address-phase owner
//  HBURST     in   3            muxed HBURST of current address-phase owner
//  HREADY     in   1            bus HREADY (slave mux output)
//  HRESP      in   2            bus HRESP (00 OKAY, 01 ERROR)
//  HGRANT     out  NUM_MASTERS  one-hot grant (next owner)
//  HMASTER    out  MW           current address-phase owner index
//  HMASTLOCK  out  1            current transfer is locked
// BEHAVIOUR
//  Reset: HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, rr_ptr=DEFAULT_MASTER, FSM=IDLE, beat_cnt=0.
//  Grant/ownership updates only on HCLK edges with HREADY=1; HREADY=0 freezes all state.
//  HMASTER<=index(HGRANT) and HMASTLOCK<=HLOCK[granted] on every HREADY=1 edge (1-cycle handover latency).
//  Round-robin: search starts at rr_ptr+1 mod N; first HBUSREQ wins; rr_ptr<=winner on handover.
//  No requests: grant DEFAULT_MASTER (park). Current owner still requesting, no others: keep grant.
//  FSM: IDLE  - owner has no live burst; re-arbitrate each HREADY edge.
//       BURST - entered when owner issues NONSEQ with HREADY=1; beat_cnt loaded from HBURST:
//               SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=0 (undefined length).
//               Decrement on each NONSEQ/SEQ beat accepted (HREADY=1). BUSY beats do not count.
//               Fixed burst: grant held until beat_cnt reaches 1 on accepted beat; HGRANT switches
//               that same edge so the new owner's NONSEQ follows the last beat with no bubble.
//               INCR: grant held while owner HBUSREQ=1; re-arbitrate when it drops.
//       -> IDLE on last beat, on HTRANS=IDLE from owner, or on HRESP=ERROR (burst terminated, re-arbitrate at
//          next HREADY=1 edge; beat_cnt<=0).
//  Simultaneous: new NONSEQ on last-beat edge reloads beat_cnt (stays BURST).
//  HTRANS=BUSY for >0 cycles: grant held, no count. HBUSREQ drop mid fixed burst: ignored until burst ends.
//  Reset mid-burst: all state to reset values immediately (async); no partial-burst recovery.
//  HGRANT always exactly one-hot; an out-of-range master index never appears on HMASTER.
// CONFIGURATION
//  AHB_ARB_LOCK_EN defined: owner with HLOCK=1 keeps grant regardless of other requests or burst end,
//    until HLOCK deasserted and a non-locked beat (or IDLE) completes; HMASTLOCK=1 for those transfers.
//  Undefined: HLOCK ignored, HMASTLOCK tied 0, arbitration purely round-robin/burst-aware.
// TESTING
//  T1 reset: HRESETn=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; no HBUSREQ after reset -> park on M0.
//  T2 RR fairness: HBUSREQ=4'b1111, SINGLE bursts -> owners 1,2,3,0,1 on successive transfers.
//  T3 INCR4 hold: M1 INCR4 with 2 wait states on beat 2, M2 requesting -> M2 granted only on beat-4
//     accept edge; HMASTER=2 exactly one HREADY edge later.
//  T4 INCR: M3 INCR 6 beats then HBUSREQ[3]=0, M0 requesting -> grant moves to M0 on next HREADY edge.
//  T5 ERROR: M1 INCR8 gets HRESP=01 on beat 3 -> FSM IDLE, M2 (requesting) granted next HREADY=1 edge.
//  T6 lock (AHB_ARB_LOCK_EN): M2 HLOCK=1, two SINGLE transfers, M0/M1 requesting -> M2 holds both,
//     HMASTLOCK=1; after HLOCK=0 grant moves to M3/M0 per rr_ptr. Without macro: HMASTLOCK stays 0.

Source files
------------

// File: rtl/ahb_arb_if.sv
// Arbitration-side AHB signals shared by the bus fabric (master modport) and the
// arbiter (slave modport).
interface ahb_arb_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst-aware handover. Define AHB_ARB_LOCK_EN to let a
// master holding HLOCK keep the bus; otherwise HLOCK is ignored and HMASTLOCK is 0.
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = 2
) (
    input logic      HCLK,
    input logic      HRESETn,
    ahb_arb_if.slave bus
);
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] RespError   = 2'b01;

    typedef enum logic {StIdle, StBurst} state_e;

    state_e        state_q, state_d;
    logic [4:0]    beat_cnt_q, beat_cnt_d;
    logic [MW-1:0] grant_idx_q, grant_idx_d;
    logic [MW-1:0] rr_ptr_q, rr_ptr_d;
    logic [MW-1:0] hmaster_q;
    logic [MW-1:0] rr_winner, rr_idx;
    logic          any_req, hold, owner_granted, owner_req;
    logic [4:0]    len;

    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            3'b000:         return 5'd1;
            3'b001:         return 5'd0;
            3'b010, 3'b011: return 5'd4;
            3'b100, 3'b101: return 5'd8;
            default:        return 5'd16;
        endcase
    endfunction

    // Walk downwards so the last hit is the first requester after rr_ptr.
    always_comb begin
        rr_winner = MW'(DEFAULT_MASTER);
        any_req   = 1'b0;
        rr_idx    = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            rr_idx = MW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (bus.HBUSREQ[rr_idx]) begin
                rr_winner = rr_idx;
                any_req   = 1'b1;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic hmastlock_q;
`endif

    always_comb begin
        owner_granted = (grant_idx_q == hmaster_q);
        owner_req     = bus.HBUSREQ[hmaster_q];
        len           = burst_len(bus.HBURST);
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        hold          = 1'b0;
        if (bus.HRESP == RespError) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
        end else if (bus.HTRANS == TransNonseq && owner_granted) begin
            // The NONSEQ itself is the first counted beat; a zero length marks INCR.
            if (len == 5'd0) begin
                hold       = owner_req;
                state_d    = owner_req ? StBurst : StIdle;
                beat_cnt_d = '0;
            end else if (len == 5'd1) begin
                state_d    = StIdle;
                beat_cnt_d = '0;
            end else begin
                hold       = 1'b1;
                state_d    = StBurst;
                beat_cnt_d = len - 5'd1;
            end
        end else if (state_q == StBurst) begin
            if (bus.HTRANS == TransIdle) begin
                state_d    = StIdle;
                beat_cnt_d = '0;
            end else if (beat_cnt_q == 5'd0) begin
                if (owner_req) begin
                    hold = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end else if (bus.HTRANS == TransBusy) begin
                hold = 1'b1;
            end else if (beat_cnt_q == 5'd1) begin
                state_d    = StIdle;
                beat_cnt_d = '0;
            end else begin
                hold       = 1'b1;
                beat_cnt_d = beat_cnt_q - 5'd1;
            end
        end
`ifdef AHB_ARB_LOCK_EN
        // Stay until the lock drops and one unlocked transfer has gone through.
        if (bus.HLOCK[grant_idx_q] || (hmastlock_q && owner_granted)) begin
            hold = 1'b1;
        end
`endif
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (!hold) begin
            grant_idx_d = rr_winner;
            if (any_req) begin
                rr_ptr_d = rr_winner;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            grant_idx_q <= MW'(DEFAULT_MASTER);
            hmaster_q   <= MW'(DEFAULT_MASTER);
            rr_ptr_q    <= MW'(DEFAULT_MASTER);
        end else if (bus.HREADY) begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            grant_idx_q <= grant_idx_d;
            hmaster_q   <= grant_idx_q;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef AHB_ARB_LOCK_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmastlock_q <= 1'b0;
        end else if (bus.HREADY) begin
            hmastlock_q <= bus.HLOCK[grant_idx_q];
        end
    end

    assign bus.HMASTLOCK = hmastlock_q;
`else
    assign bus.HMASTLOCK = 1'b0;
`endif

    assign bus.HGRANT  = NUM_MASTERS'(1) << grant_idx_q;
    assign bus.HMASTER = hmaster_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: stimulus pushes the expected post-edge
// HGRANT/HMASTER/HMASTLOCK into a scoreboard that a monitor drains after each edge.
module tb_ahb_bus_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned MW = 2;

    localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
    localparam logic [2:0] BSINGLE = 3'b000, BINCR = 3'b001, BINCR4 = 3'b011, BINCR8 = 3'b101;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    ahb_arb_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(0),
        .MW            (MW)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string name, input logic rstn, input logic [3:0] req,
                        input logic [3:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready, input logic [1:0] resp,
                        input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        @(negedge HCLK);
        HRESETn        = rstn;
        bus.HBUSREQ    = req;
        bus.HLOCK      = lock;
        bus.HTRANS     = trans;
        bus.HBURST     = burst;
        bus.HREADY     = ready;
        bus.HRESP      = resp;
        e.name         = name;
        e.grant        = eg;
        e.master       = em;
        e.lock         = el;
        sb_q.push_back(e);
    endtask

    always @(posedge HCLK) begin : monitor
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".grant"}, bus.HGRANT, e.grant);
            check({e.name, ".master"}, {2'b00, bus.HMASTER}, {2'b00, e.master});
            check({e.name, ".lock"}, {3'b000, bus.HMASTLOCK}, {3'b000, e.lock});
        end
    end

    initial begin
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = TI;
        bus.HBURST  = BSINGLE;
        bus.HREADY  = 1'b1;
        bus.HRESP   = OK;

        // T1 reset and park
        step("t1_rst0", 0, 4'b0000, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);
        step("t1_rst1", 0, 4'b0000, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);
        step("t1_park0", 1, 4'b0000, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);
        step("t1_park1", 1, 4'b0000, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);

        // T2 round-robin over SINGLE transfers, then a wait state freezes everything
        step("t2_rr1", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b0010, 0, 0);
        step("t2_rr2", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b0100, 1, 0);
        step("t2_rr3", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b1000, 2, 0);
        step("t2_rr4", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b0001, 3, 0);
        step("t2_rr5", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b0010, 0, 0);
        step("t2_rr6", 1, 4'b1111, 0, TN, BSINGLE, 1, OK, 4'b0100, 1, 0);
        step("t2_wait", 1, 4'b1111, 0, TN, BSINGLE, 0, OK, 4'b0100, 1, 0);

        // T3 INCR4 from M1 with two wait states, M2 waiting
        step("t3_g1", 1, 4'b0010, 0, TI, BSINGLE, 1, OK, 4'b0010, 2, 0);
        step("t3_own1", 1, 4'b0010, 0, TI, BSINGLE, 1, OK, 4'b0010, 1, 0);
        step("t3_b1", 1, 4'b0110, 0, TN, BINCR4, 1, OK, 4'b0010, 1, 0);
        step("t3_ws1", 1, 4'b0110, 0, TS, BINCR4, 0, OK, 4'b0010, 1, 0);
        step("t3_ws2", 1, 4'b0110, 0, TS, BINCR4, 0, OK, 4'b0010, 1, 0);
        step("t3_b2", 1, 4'b0110, 0, TS, BINCR4, 1, OK, 4'b0010, 1, 0);
        step("t3_b3", 1, 4'b0110, 0, TS, BINCR4, 1, OK, 4'b0010, 1, 0);
        step("t3_b4", 1, 4'b0110, 0, TS, BINCR4, 1, OK, 4'b0100, 1, 0);
        step("t3_hand", 1, 4'b0100, 0, TI, BSINGLE, 1, OK, 4'b0100, 2, 0);

        // T4 undefined-length INCR from M3 with a BUSY, released by dropping HBUSREQ
        step("t4_g3", 1, 4'b1000, 0, TI, BSINGLE, 1, OK, 4'b1000, 2, 0);
        step("t4_own3", 1, 4'b1000, 0, TI, BSINGLE, 1, OK, 4'b1000, 3, 0);
        step("t4_b1", 1, 4'b1001, 0, TN, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_b2", 1, 4'b1001, 0, TS, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_busy", 1, 4'b1001, 0, TB, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_b3", 1, 4'b1001, 0, TS, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_b4", 1, 4'b1001, 0, TS, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_b5", 1, 4'b1001, 0, TS, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_b6", 1, 4'b1001, 0, TS, BINCR, 1, OK, 4'b1000, 3, 0);
        step("t4_drop", 1, 4'b0001, 0, TB, BINCR, 1, OK, 4'b0001, 3, 0);
        step("t4_hand", 1, 4'b0001, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);

        // T5 INCR8 from M1 cut short by a two-cycle ERROR; HBUSREQ drop is ignored
        step("t5_g1", 1, 4'b0010, 0, TI, BSINGLE, 1, OK, 4'b0010, 0, 0);
        step("t5_own1", 1, 4'b0010, 0, TI, BSINGLE, 1, OK, 4'b0010, 1, 0);
        step("t5_b1", 1, 4'b0110, 0, TN, BINCR8, 1, OK, 4'b0010, 1, 0);
        step("t5_b2", 1, 4'b0100, 0, TS, BINCR8, 1, OK, 4'b0010, 1, 0);
        step("t5_b3", 1, 4'b0100, 0, TS, BINCR8, 1, OK, 4'b0010, 1, 0);
        step("t5_err0", 1, 4'b0100, 0, TS, BINCR8, 0, ERR, 4'b0010, 1, 0);
        step("t5_err1", 1, 4'b0100, 0, TS, BINCR8, 1, ERR, 4'b0100, 1, 0);
        step("t5_hand", 1, 4'b0100, 0, TI, BSINGLE, 1, OK, 4'b0100, 2, 0);

        // T6 locked transfers from M2 with M0/M1 requesting
`ifdef AHB_ARB_LOCK_EN
        step("t6_lk1", 1, 4'b0111, 4'b0100, TN, BSINGLE, 1, OK, 4'b0100, 2, 1);
        step("t6_lk2", 1, 4'b0111, 4'b0100, TN, BSINGLE, 1, OK, 4'b0100, 2, 1);
        step("t6_unlk", 1, 4'b0111, 4'b0000, TN, BSINGLE, 1, OK, 4'b0100, 2, 0);
`else
        step("t6_lk1", 1, 4'b0111, 4'b0100, TN, BSINGLE, 1, OK, 4'b0001, 2, 0);
        step("t6_lk2", 1, 4'b0111, 4'b0100, TN, BSINGLE, 1, OK, 4'b0010, 0, 0);
        step("t6_unlk", 1, 4'b0111, 4'b0000, TN, BSINGLE, 1, OK, 4'b0100, 1, 0);
`endif
        step("t6_rel", 1, 4'b0111, 4'b0000, TI, BSINGLE, 1, OK, 4'b0001, 2, 0);
        step("t6_next", 1, 4'b0111, 4'b0000, TI, BSINGLE, 1, OK, 4'b0010, 0, 0);

        // Reset in the middle of an INCR4 restores park state and rr_ptr
        step("t7_own1", 1, 4'b0010, 0, TI, BSINGLE, 1, OK, 4'b0010, 1, 0);
        step("t7_b1", 1, 4'b0011, 0, TN, BINCR4, 1, OK, 4'b0010, 1, 0);
        step("t7_b2", 1, 4'b0011, 0, TS, BINCR4, 1, OK, 4'b0010, 1, 0);
        step("t7_rst", 0, 4'b0011, 0, TS, BINCR4, 1, OK, 4'b0001, 0, 0);
        step("t7_park", 1, 4'b0000, 0, TI, BSINGLE, 1, OK, 4'b0001, 0, 0);
        step("t7_rrptr", 1, 4'b1111, 0, TI, BSINGLE, 1, OK, 4'b0010, 0, 0);

        repeat (3) @(negedge HCLK);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
